// File: rtl/adbg_jsp_apb_host.sv
// APB initiator for the JTAG serial port slave: polls LSR, drains RBR into an rx
// stream and feeds THR from a tx stream. One transfer at a time, idle cycle between.
module adbg_jsp_apb_host #(
   parameter int         POLL_CYCLES = 16,
   parameter logic [7:0] INIT_IER    = 8'h01
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   output logic       PSEL,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [2:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic [7:0] PRDATA,
   input  logic       PREADY,
   input  logic       PSLVERR,
   input  logic       int_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       err_o
);

   // Streams: an rx byte moves on any cycle with rx_valid_o & rx_ready_i; tx_valid_i
   // holds tx_data_i until tx_ready_o, a single-cycle strobe on the THR write completion.
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_POLL, S_RD_RBR, S_WR_THR} state_t;

   localparam logic [7:0] POLL_RELOAD = 8'(POLL_CYCLES - 1);
   localparam logic [2:0] ADDR_RBR    = 3'd0;
   localparam logic [2:0] ADDR_IER    = 3'd1;
   localparam logic [2:0] ADDR_LSR    = 3'd5;

   state_t     state_q, state_d;
   logic       psel_d, penable_d, pwrite_d;
   logic [2:0] paddr_d;
   logic [7:0] pwdata_d;
   logic [7:0] cnt_q, cnt_d;
   logic       last_tx_q, last_tx_d;
   logic [7:0] rx_data_d;
   logic       rx_valid_d;
   logic       done, rx_ok, tx_ok;

   assign done       = PSEL & PENABLE & PREADY;
   assign tx_ready_o = done & ~PSLVERR & (state_q == S_WR_THR);
   assign err_o      = done & PSLVERR;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= S_INIT;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= 3'd0;
         PWDATA     <= 8'h00;
         cnt_q      <= POLL_RELOAD;
         last_tx_q  <= 1'b0;
         rx_data_o  <= 8'h00;
         rx_valid_o <= 1'b0;
      end else begin
         state_q    <= state_d;
         PSEL       <= psel_d;
         PENABLE    <= penable_d;
         PWRITE     <= pwrite_d;
         PADDR      <= paddr_d;
         PWDATA     <= pwdata_d;
         cnt_q      <= cnt_d;
         last_tx_q  <= last_tx_d;
         rx_data_o  <= rx_data_d;
         rx_valid_o <= rx_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      psel_d     = PSEL;
      penable_d  = PENABLE;
      pwrite_d   = PWRITE;
      paddr_d    = PADDR;
      pwdata_d   = PWDATA;
      cnt_d      = cnt_q;
      last_tx_d  = last_tx_q;
      rx_data_d  = rx_data_o;
      rx_valid_d = rx_valid_o & ~rx_ready_i;
      rx_ok      = 1'b0;
      tx_ok      = 1'b0;
      if (state_q == S_IDLE) begin
         // IDLE launches the LSR setup directly so the wait is exactly POLL_CYCLES.
         if (cnt_q == 8'd0 || int_i) begin
            state_d  = S_POLL;
            cnt_d    = POLL_RELOAD;
            psel_d   = 1'b1;
            pwrite_d = 1'b0;
            paddr_d  = ADDR_LSR;
            pwdata_d = 8'h00;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end else if (!PSEL) begin
         psel_d   = 1'b1;
         pwrite_d = 1'b0;
         pwdata_d = 8'h00;
         case (state_q)
            S_INIT:   begin pwrite_d = 1'b1; paddr_d = ADDR_IER; pwdata_d = INIT_IER;  end
            S_WR_THR: begin pwrite_d = 1'b1; paddr_d = ADDR_RBR; pwdata_d = tx_data_i; end
            S_RD_RBR: paddr_d = ADDR_RBR;
            default:  paddr_d = ADDR_LSR;
         endcase
      end else if (!PENABLE) begin
         penable_d = 1'b1;
      end else if (PREADY) begin
         psel_d    = 1'b0;
         penable_d = 1'b0;
         case (state_q)
            S_INIT: state_d = S_IDLE;
            S_RD_RBR: begin
               if (!PSLVERR) begin
                  rx_data_d  = PRDATA;
                  rx_valid_d = 1'b1;
                  last_tx_d  = 1'b0;
               end
               state_d = S_POLL;
            end
            S_WR_THR: begin
               if (!PSLVERR) last_tx_d = 1'b1;
               state_d = S_POLL;
            end
            default: begin
               rx_ok = PRDATA[0] & ~rx_valid_o;
               tx_ok = PRDATA[5] & tx_valid_i;
               if (PSLVERR || (!rx_ok && !tx_ok)) state_d = S_IDLE;
               else if (rx_ok && tx_ok)           state_d = last_tx_q ? S_RD_RBR : S_WR_THR;
               else                               state_d = rx_ok ? S_RD_RBR : S_WR_THR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adbg_jsp_apb_host.sv
// Directed bench for adbg_jsp_apb_host: behavioural JSP slave, transfer monitor,
// vector table for the poll decisions and hand sequences for the multi-cycle cases.
module tb_adbg_jsp_apb_host;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       PSEL, PENABLE, PWRITE;
   logic [2:0] PADDR;
   logic [7:0] PWDATA, PRDATA;
   logic       PREADY, PSLVERR;
   logic       int_i;
   logic [7:0] tx_data_i;
   logic       tx_valid_i, tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o, rx_ready_i, err_o;

   adbg_jsp_apb_host #(.POLL_CYCLES(16), .INIT_IER(8'h01)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .int_i(int_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .err_o(err_o)
   );

   // clock / reset
   always #5 PCLK = ~PCLK;

   // slave model: LSR.DR while loaded bytes exceed RBR reads, programmable wait states
   logic       thre = 1'b0;
   int         rx_loaded = 0;
   int         rbr_reads = 0;
   logic [7:0] rbr_v = 8'h00;
   int         wait_n = 0;
   int         acc_cnt = 0;
   logic       slverr_en = 1'b0;

   assign PREADY  = (acc_cnt >= wait_n);
   assign PSLVERR = slverr_en & PWRITE & (PADDR == 3'd0);
   assign PRDATA  = (PADDR == 3'd5) ? {2'b00, thre, 4'b0000, (rx_loaded > rbr_reads)} :
                    (PADDR == 3'd0) ? rbr_v : 8'h00;

   always @(posedge PCLK) begin
      if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
      else                            acc_cnt <= 0;
   end

   // monitor: logs completed transfers, checks APB sequencing and strobes
   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] data;
      logic       err;
      int         gap;
      int         en;
   } tr_t;

   tr_t        log_q[$];
   logic [7:0] got_q[$];
   int gap_cnt = 0, cur_gap = 0, en_cnt = 0;
   int tx_pulses = 0, err_pulses = 0, proto_bad = 0, pulse_bad = 0;
   logic prev_setup = 1'b0, prev_done = 1'b0;
   logic [2:0] s_addr;
   logic       s_wr;
   logic [7:0] s_wdata;

   always @(negedge PCLK) begin
      if (!PRESETn) begin
         gap_cnt    = 0;
         prev_setup = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_done && PSEL) proto_bad++;
         if (prev_setup && !(PSEL && PENABLE)) proto_bad++;
         prev_setup = 1'b0;
         prev_done  = 1'b0;
         if (!PSEL) begin
            gap_cnt++;
            if (PENABLE) proto_bad++;
         end else if (!PENABLE) begin
            cur_gap = gap_cnt; gap_cnt = 0; en_cnt = 0;
            s_addr = PADDR; s_wr = PWRITE; s_wdata = PWDATA;
            prev_setup = 1'b1;
         end else begin
            en_cnt++;
            if (PADDR !== s_addr || PWRITE !== s_wr || PWDATA !== s_wdata) proto_bad++;
            if (PREADY) begin
               log_q.push_back('{PWRITE, PADDR, PWRITE ? PWDATA : PRDATA, PSLVERR, cur_gap, en_cnt});
               if (!PWRITE && PADDR == 3'd0 && !PSLVERR) rbr_reads++;
               prev_done = 1'b1;
            end
         end
         if (tx_ready_o) begin
            tx_pulses++;
            if (!(PSEL && PENABLE && PREADY && PWRITE && PADDR == 3'd0 && !PSLVERR)) pulse_bad++;
         end
         if (err_o) begin
            err_pulses++;
            if (!(PSEL && PENABLE && PREADY && PSLVERR)) pulse_bad++;
         end
         if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
      end
   end

   // scoreboard state
   logic [7:0] exp_q[$];
   int total = 0, bad = 0;
   int rd_idx = 0, got_idx = 0, drop_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one cycle; the tx source withdraws its byte once a tx_ready_o strobe was seen
   task automatic tick();
      @(posedge PCLK);
      #2;
      if (tx_pulses != drop_seen) begin
         tx_valid_i = 1'b0;
         drop_seen  = tx_pulses;
      end
   endtask

   task automatic get_tr(output tr_t t);
      int n = 0;
      while (log_q.size() <= rd_idx && n < 500) begin tick(); n++; end
      check("tr_timeout", (log_q.size() > rd_idx), 1);
      if (log_q.size() > rd_idx) begin t = log_q[rd_idx]; rd_idx++; end
      else t = '{1'b0, 3'd7, 8'h00, 1'b0, 0, 0};
   endtask

   task automatic find_poll();
      tr_t t;
      bit  found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         get_tr(t);
         if (!t.wr && t.addr == 3'd5) found = 1'b1;
      end
      check("find_poll", found, 1);
   endtask

   task automatic quiet();
      thre = 1'b0; rx_loaded = rbr_reads; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
      int_i = 1'b0; slverr_en = 1'b0; wait_n = 0;
      repeat (40) tick();
      rd_idx = log_q.size();
   endtask

   task automatic sb_check(input string name);
      logic [7:0] e;
      repeat (60) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(name, (got_idx < got_q.size()) ? {1'b1, got_q[got_idx]} : 9'h000, {1'b1, e});
         if (got_idx < got_q.size()) got_idx++;
      end
      check({name, "_extra"}, got_q.size() - got_idx, 0);
   endtask

   typedef struct {
      string      name;
      logic       thre;
      int         rx_n;
      logic [7:0] rbr;
      logic       txv;
      logic [7:0] txd;
      logic       exp_wr;
      logic [2:0] exp_addr;
      logic [7:0] exp_data;
      int         exp_gap;
   } vec_t;

   vec_t vecs[4];

   initial begin
      tr_t t;
      int  p0, e0, n;

      vecs[0] = '{"neither_idle",  1'b0, 0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00, 16};
      vecs[1] = '{"rx_only",       1'b0, 1, 8'h41, 1'b0, 8'h00, 1'b0, 3'd0, 8'h41, 1};
      vecs[2] = '{"thre_no_tx",    1'b1, 0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd5, 8'h20, 16};
      vecs[3] = '{"tx_only",       1'b1, 0, 8'h00, 1'b1, 8'hA5, 1'b1, 3'd0, 8'hA5, 1};

      PRESETn = 1'b0; int_i = 1'b0; tx_data_i = 8'h00; tx_valid_i = 1'b0; rx_ready_i = 1'b1;
      repeat (3) @(posedge PCLK);
      #2;
      check("reset_state", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready_o, rx_valid_o,
                            rx_data_o, err_o}, 0);
      PRESETn = 1'b1;

      // IER init write, then 16 idle cycles before the first LSR read
      get_tr(t);
      check("init_ier_write", {t.wr, t.addr, t.data}, {1'b1, 3'd1, 8'h01});
      get_tr(t);
      check("first_poll", {t.wr, t.addr, 8'(t.gap)}, {1'b0, 3'd5, 8'd16});

      foreach (vecs[i]) begin
         quiet();
         thre = vecs[i].thre; rbr_v = vecs[i].rbr;
         rx_loaded = rbr_reads + vecs[i].rx_n;
         tx_data_i = vecs[i].txd; tx_valid_i = vecs[i].txv;
         for (int k = 0; k < vecs[i].rx_n; k++) exp_q.push_back(vecs[i].rbr);
         rd_idx = log_q.size();
         find_poll();
         get_tr(t);
         check(vecs[i].name, {t.wr, t.addr, t.data, 8'(t.gap)},
               {vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_data, 8'(vecs[i].exp_gap)});
      end
      sb_check("rx_table");

      // both sources pending after a TX service: RX, TX, RX, then idle
      quiet();
      thre = 1'b1; rbr_v = 8'h42; rx_loaded = rbr_reads + 2;
      tx_data_i = 8'h5A; tx_valid_i = 1'b1;
      exp_q.push_back(8'h42); exp_q.push_back(8'h42);
      p0 = tx_pulses; rd_idx = log_q.size();
      find_poll();
      get_tr(t); check("alt_rd1",   {t.wr, t.addr, t.data}, {1'b0, 3'd0, 8'h42});
      get_tr(t); check("alt_poll1", {t.wr, t.addr, t.data, 8'(t.gap)}, {1'b0, 3'd5, 8'h21, 8'd1});
      get_tr(t); check("alt_wr",    {t.wr, t.addr, t.data}, {1'b1, 3'd0, 8'h5A});
      get_tr(t); check("alt_poll2", {t.wr, t.addr, t.data}, {1'b0, 3'd5, 8'h21});
      get_tr(t); check("alt_rd2",   {t.wr, t.addr, t.data}, {1'b0, 3'd0, 8'h42});
      get_tr(t); check("alt_poll3", {t.wr, t.addr, t.data, 8'(t.gap)}, {1'b0, 3'd5, 8'h20, 8'd1});
      check("alt_tx_pulses", tx_pulses - p0, 1);
      sb_check("rx_alt");

      // consumer stalled: RBR is not read again while rx_valid_o is held
      quiet();
      rx_ready_i = 1'b0; rbr_v = 8'h77; rx_loaded = rbr_reads + 2;
      find_poll();
      get_tr(t); check("stall_rd", {t.wr, t.addr, t.data}, {1'b0, 3'd0, 8'h77});
      for (int k = 0; k < 3; k++) begin
         get_tr(t);
         check("stall_poll_only", {t.wr, t.addr, t.data}, {1'b0, 3'd5, 8'h01});
      end
      check("stall_rx_held", {rx_valid_o, rx_data_o}, {1'b1, 8'h77});
      exp_q.push_back(8'h77); exp_q.push_back(8'h77);
      rx_ready_i = 1'b1;
      sb_check("rx_stall");

      // three wait states on the THR write
      quiet();
      wait_n = 3; thre = 1'b1; tx_data_i = 8'hC3; tx_valid_i = 1'b1;
      p0 = tx_pulses;
      find_poll();
      get_tr(t);
      check("wait_thr", {t.wr, t.addr, t.data, 8'(t.en)}, {1'b1, 3'd0, 8'hC3, 8'd4});
      tick();
      check("wait_tx_pulses", tx_pulses - p0, 1);

      // slave error on THR write: err strobe, no accept, same byte retried
      quiet();
      slverr_en = 1'b1; thre = 1'b1; tx_data_i = 8'h3C; tx_valid_i = 1'b1;
      p0 = tx_pulses; e0 = err_pulses;
      find_poll();
      get_tr(t);
      slverr_en = 1'b0;
      check("slverr_wr", {t.wr, t.addr, t.data, t.err}, {1'b1, 3'd0, 8'h3C, 1'b1});
      check("slverr_counts", {8'(err_pulses - e0), 8'(tx_pulses - p0)}, {8'd1, 8'd0});
      get_tr(t); check("slverr_repoll", {t.wr, t.addr}, {1'b0, 3'd5});
      get_tr(t); check("slverr_retry", {t.wr, t.addr, t.data, t.err}, {1'b1, 3'd0, 8'h3C, 1'b0});
      tick();
      check("slverr_retry_pulse", tx_pulses - p0, 1);

      // interrupt cuts the idle wait short
      quiet();
      find_poll();
      int_i = 1'b1;
      get_tr(t);
      int_i = 1'b0;
      check("int_poll_gap", {t.wr, t.addr, 8'(t.gap)}, {1'b0, 3'd5, 8'd1});

      // asynchronous reset in the middle of a THR access
      quiet();
      wait_n = 20; thre = 1'b1; tx_data_i = 8'h99; tx_valid_i = 1'b1;
      p0 = tx_pulses; n = 0;
      while (!(PSEL && PENABLE && PWRITE) && n < 300) begin tick(); n++; end
      check("rst_reach_thr", (PSEL && PENABLE && PWRITE), 1);
      repeat (3) tick();
      PRESETn = 1'b0;
      #1;
      check("rst_async_drop", {PSEL, PENABLE}, 0);
      tick();
      check("rst_no_accept", {8'(tx_pulses - p0), 7'd0, rx_valid_o}, 0);
      wait_n = 0; tx_valid_i = 1'b0;
      rd_idx = log_q.size();
      PRESETn = 1'b1;
      get_tr(t);
      check("rst_reinit", {t.wr, t.addr, t.data}, {1'b1, 3'd1, 8'h01});

      check("apb_sequencing", proto_bad, 0);
      check("strobe_placement", pulse_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
